serial_mag_cmp: RTL
===================

SERIAL_MAG_CMP -- requirements
Module: serial_mag_cmp

Interface
REQ-001 SHALL have parameter W, default 8, operand width; SHALL be even and at least 2.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to compare a against b; sampled only in IDLE.
REQ-005 SHALL have port a  input  W  unsigned operand A.
REQ-006 SHALL have port b  input  W  unsigned operand B.
REQ-007 SHALL have port busy  output  1  high while a comparison is in progress (RUN).
REQ-008 SHALL have port done  output  1  one-cycle pulse when the result becomes valid.
REQ-009 SHALL have port gt  output  1  registered result A>B.
REQ-010 SHALL have port eq  output  1  registered result A==B.
REQ-011 SHALL have port lt  output  1  registered result A<B.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch a and b, set slice index to W/2-1 and enter RUN.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE with gt/eq/lt unchanged.
REQ-015 Each RUN cycle SHALL compare exactly one 2-bit slice, [2i+1:2i] of both latched operands, MSB slice first.
REQ-016 When a slice is unequal, the block SHALL register gt/lt from that slice, clear eq and enter DONE (early termination).
REQ-017 When the slice is equal and index>0, the block SHALL decrement the index and stay in RUN.
REQ-018 When the slice is equal and index==0, the block SHALL register eq=1, gt=0, lt=0 and enter DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 Latency: done SHALL be high N cycles after the edge that samples start, N = number of slices examined (1..W/2).
REQ-021 gt, eq and lt SHALL be mutually exclusive once valid and SHALL hold their value until the next result is registered.
REQ-022 The flags SHALL change only on the edge entering DONE; they SHALL NOT glitch during RUN.
REQ-023 start SHALL be ignored in RUN and DONE; a, b changes after latching SHALL NOT affect the result in progress.
REQ-024 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, gt=0, eq=0, lt=0 and index=0, from any state.
REQ-026 rst SHALL take priority over start on the same edge.
REQ-027 Reset mid-RUN SHALL abort the comparison with no done pulse; the next start after reset release SHALL be accepted normally.

Structure
REQ-028 Shared package cmp_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default width constant.
REQ-029 Sub-module slice_cmp2 SHALL be instantiated once: a combinational 2-bit magnitude comparator with outputs gt, eq and lt.
REQ-030 Index width SHALL be clog2(W/2), minimum 1.

Verification (W=8)
REQ-031 a=8'hA5, b=8'hA5, start pulse -> done 4 cycles later; eq=1, gt=0, lt=0; busy high for 4 cycles.
REQ-032 a=8'hC0, b=8'h40 -> MSB slice 11 vs 01; done 1 cycle after start; gt=1, eq=0, lt=0.
REQ-033 a=8'h12, b=8'h13 -> done 4 cycles after start; lt=1, gt=0, eq=0.
REQ-034 start with a=8'hFF, b=8'h00 held high continuously, and operands changed to 8'h00/8'hFF mid-RUN -> first result gt=1; start in the DONE cycle is ignored; the next comparison begins from the IDLE cycle.
REQ-035 rst=1 for one cycle during RUN of 8'h12 vs 8'h13 -> next cycle busy=0, done=0, flags=0, no done pulse; a fresh start afterwards yields the correct result.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package cmp_pkg;

  localparam int unsigned CMP_DEFAULT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Width of the slice index: clog2(number of 2-bit slices), never below 1.
  function automatic int unsigned idx_width(input int unsigned w);
    return ((w / 2) > 1) ? $clog2(w / 2) : 1;
  endfunction

endpackage

// File: rtl/slice_cmp2.sv
// Combinational magnitude comparator for one 2-bit slice.
module slice_cmp2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  always_comb begin
    gt = (a > b);
    eq = (a == b);
    lt = (a < b);
  end

endmodule

// File: rtl/serial_mag_cmp.sv
// Serial unsigned comparator: walks 2-bit slices MSB first, one per cycle,
// stopping at the first unequal slice.
module serial_mag_cmp
  import cmp_pkg::*;
#(
  parameter int unsigned W = CMP_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

  localparam int unsigned NS = W / 2;
  localparam int unsigned IW = idx_width(W);

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, b_q;
  logic [IW-1:0]  idx_q;
  logic [1:0]     sl_a, sl_b;
  logic           s_gt, s_eq, s_lt;

  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (idx_q == IW'(i)) begin
        sl_a = a_q[2*i +: 2];
        sl_b = b_q[2*i +: 2];
      end
    end
  end

  slice_cmp2 u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .gt (s_gt),
    .eq (s_eq),
    .lt (s_lt)
  );

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (!s_eq || (idx_q == '0)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            idx_q <= IW'(NS - 1);
          end
        end
        RUN: begin
          // Flags only move on the edge that enters DONE.
          if (!s_eq) begin
            gt <= s_gt;
            eq <= 1'b0;
            lt <= s_lt;
          end else if (idx_q != '0) begin
            idx_q <= idx_q - IW'(1);
          end else begin
            gt <= 1'b0;
            eq <= 1'b1;
            lt <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
